// File: rtl/mouse_port_ctl.sv
// Mouse/joystick port controller: accumulates mouse deltas into thresholded
// direction flags and presents either mouse or joystick state on port 177714.
module mouse_port_ctl #(
    parameter int THRESH = 4,
    parameter int ACC_W  = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pkt_valid,
    input  logic [8:0]  pkt_dx,
    input  logic [8:0]  pkt_dy,
    input  logic        pkt_btn_l,
    input  logic        pkt_btn_r,
    input  logic [7:0]  joy,
    input  logic        wr_stb,
    input  logic        wr_sel_lo,
    input  logic [15:0] wr_data,
    output logic [15:0] port_data,
    output logic        mouse_mode,
    output logic        mouse_en
);
    // Two guard bits cover acc + 9-bit delta +/- THRESH without overflow.
    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] TH   = SW'(THRESH);
    localparam logic signed [SW-1:0] NTH  = -TH;
    localparam logic signed [SW-1:0] LIMV = SW'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [SW-1:0] NLIM = -LIMV;

    logic signed [ACC_W-1:0] r_acc_x, r_acc_y;
    logic [3:0]              r_flags;
    logic                    r_btn_l, r_btn_r, r_mouse_mode, r_mouse_en;

    logic                    w_wr, w_add;
    logic signed [SW-1:0]    w_ext_x, w_ext_y, w_dx, w_dy, w_sum_x, w_sum_y;
    logic                    w_x_pos, w_x_neg, w_y_pos, w_y_neg;
    logic signed [ACC_W-1:0] w_next_x, w_next_y;
    logic                    w_unused;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SW-1:0] v);
        if (v > LIMV)      sat = LIMV[ACC_W-1:0];
        else if (v < NLIM) sat = NLIM[ACC_W-1:0];
        else               sat = v[ACC_W-1:0];
    endfunction

    always_comb begin
        w_wr    = wr_stb & wr_sel_lo;
        w_add   = pkt_valid & r_mouse_en;
        w_ext_x = SW'(r_acc_x);
        w_ext_y = SW'(r_acc_y);
        w_dx    = w_add ? SW'($signed(pkt_dx)) : '0;
        w_dy    = w_add ? SW'($signed(pkt_dy)) : '0;
        w_y_pos = r_mouse_en & ~r_flags[0] & ~r_flags[2] & (w_ext_y >= TH);
        w_y_neg = r_mouse_en & ~r_flags[0] & ~r_flags[2] & (w_ext_y <= NTH);
        w_x_pos = r_mouse_en & ~r_flags[1] & ~r_flags[3] & (w_ext_x >= TH);
        w_x_neg = r_mouse_en & ~r_flags[1] & ~r_flags[3] & (w_ext_x <= NTH);
        w_sum_y = w_ext_y + w_dy - (w_y_pos ? TH : '0) + (w_y_neg ? TH : '0);
        w_sum_x = w_ext_x + w_dx - (w_x_pos ? TH : '0) + (w_x_neg ? TH : '0);
        w_next_y = sat(w_sum_y);
        w_next_x = sat(w_sum_x);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_x      <= '0;
            r_acc_y      <= '0;
            r_flags      <= '0;
            r_btn_l      <= 1'b0;
            r_btn_r      <= 1'b0;
            r_mouse_mode <= 1'b0;
            r_mouse_en   <= 1'b0;
        end else begin
            if (pkt_valid) begin
                r_btn_l <= pkt_btn_l;
                r_btn_r <= pkt_btn_r;
            end
            if (joy != 8'h00)   r_mouse_mode <= 1'b0;
            else if (pkt_valid) r_mouse_mode <= 1'b1;
            // An accepted write freezes both axes for the cycle, even when it keeps the mouse enabled.
            if (w_wr) begin
                r_mouse_en <= wr_data[3];
                if (!wr_data[3]) begin
                    r_flags <= '0;
                    r_acc_x <= '0;
                    r_acc_y <= '0;
                end
            end else begin
                r_acc_x <= w_next_x;
                r_acc_y <= w_next_y;
                if (w_y_pos) r_flags[0] <= 1'b1;
                if (w_x_pos) r_flags[1] <= 1'b1;
                if (w_y_neg) r_flags[2] <= 1'b1;
                if (w_x_neg) r_flags[3] <= 1'b1;
            end
        end
    end

    assign port_data  = r_mouse_mode ? {9'b0, r_btn_r, r_btn_l, 1'b0, r_flags} : {8'b0, joy};
    assign mouse_mode = r_mouse_mode;
    assign mouse_en   = r_mouse_en;
    assign w_unused   = ^{wr_data[15:4], wr_data[2:0]};
endmodule

// File: tb/tb_mouse_port_ctl.sv
// Bench for mouse_port_ctl: integer-level model checked every cycle plus
// hand-computed literal checkpoints.
module tb_mouse_port_ctl;
    localparam int THRESH = 4;
    localparam int LIM    = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pkt_valid = 1'b0;
    logic [8:0]  pkt_dx = '0, pkt_dy = '0;
    logic        pkt_btn_l = 1'b0, pkt_btn_r = 1'b0;
    logic [7:0]  joy = '0;
    logic        wr_stb = 1'b0, wr_sel_lo = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] port_data;
    logic        mouse_mode, mouse_en;

    int n_tests = 0;
    int n_fail  = 0;

    mouse_port_ctl #(.THRESH(THRESH), .ACC_W(11)) dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid),
        .pkt_dx(pkt_dx), .pkt_dy(pkt_dy),
        .pkt_btn_l(pkt_btn_l), .pkt_btn_r(pkt_btn_r),
        .joy(joy), .wr_stb(wr_stb), .wr_sel_lo(wr_sel_lo), .wr_data(wr_data),
        .port_data(port_data), .mouse_mode(mouse_mode), .mouse_en(mouse_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Model state, in plain integers
    int   m_ax, m_ay;
    bit   m_f[4];
    bit   m_bl, m_br, m_mode, m_en;
    bit   m_valid = 0;

    function automatic int clamp(input int v);
        if (v > LIM)  return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    always @(posedge clk) begin
        int d, nv;
        if (reset) begin
            m_ax = 0; m_ay = 0;
            foreach (m_f[i]) m_f[i] = 0;
            m_bl = 0; m_br = 0; m_mode = 0; m_en = 0;
            m_valid = 1;
        end else begin
            if (pkt_valid) begin m_bl = pkt_btn_l; m_br = pkt_btn_r; end
            if (joy != 0) m_mode = 0;
            else if (pkt_valid) m_mode = 1;
            if (wr_stb && wr_sel_lo) begin
                m_en = wr_data[3];
                if (!wr_data[3]) begin
                    m_ax = 0; m_ay = 0;
                    foreach (m_f[i]) m_f[i] = 0;
                end
            end else if (m_en) begin
                d  = pkt_valid ? int'($signed(pkt_dy)) : 0;
                nv = m_ay + d;
                if (!m_f[0] && !m_f[2]) begin
                    if (m_ay >= THRESH)       begin m_f[0] = 1; nv -= THRESH; end
                    else if (m_ay <= -THRESH) begin m_f[2] = 1; nv += THRESH; end
                end
                m_ay = clamp(nv);
                d  = pkt_valid ? int'($signed(pkt_dx)) : 0;
                nv = m_ax + d;
                if (!m_f[1] && !m_f[3]) begin
                    if (m_ax >= THRESH)       begin m_f[1] = 1; nv -= THRESH; end
                    else if (m_ax <= -THRESH) begin m_f[3] = 1; nv += THRESH; end
                end
                m_ax = clamp(nv);
            end
        end
    end

    always @(negedge clk) begin
        int exp_pd;
        if (m_valid) begin
            exp_pd = m_mode ? ((int'(m_br) << 6) | (int'(m_bl) << 5) | (int'(m_f[3]) << 3) |
                               (int'(m_f[2]) << 2) | (int'(m_f[1]) << 1) | int'(m_f[0]))
                            : int'(joy);
            chk("port_data", int'(port_data), exp_pd);
            chk("mouse_mode", int'(mouse_mode), int'(m_mode));
            chk("mouse_en", int'(mouse_en), int'(m_en));
            chk("acc_x", int'(dut.r_acc_x), m_ax);
            chk("acc_y", int'(dut.r_acc_y), m_ay);
        end
    end

    // One cycle of stimulus; strobes drop again right after the edge.
    task automatic drive(input bit ws, input bit sel, input logic [15:0] wd,
                         input bit pv, input int dx, input int dy, input bit bl, input bit br);
        wr_stb = ws; wr_sel_lo = sel; wr_data = wd;
        pkt_valid = pv; pkt_dx = 9'(dx); pkt_dy = 9'(dy);
        pkt_btn_l = bl; pkt_btn_r = br;
        @(posedge clk); #1;
        wr_stb = 0; wr_sel_lo = 0; pkt_valid = 0;
    endtask

    task automatic wr(input logic [15:0] wd, input bit sel);
        drive(1, sel, wd, 0, 0, 0, 0, 0);
    endtask

    task automatic pkt(input int dx, input int dy, input bit bl, input bit br);
        drive(0, 0, '0, 1, dx, dy, bl, br);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset_port", int'(port_data), 16'h0000);
        chk("reset_en", int'(mouse_en), 0);

        // Enable, dy=+5: flag up visible one edge after the packet edge
        wr(16'h0008, 1);
        pkt(0, 5, 0, 0);
        @(negedge clk);
        chk("dy5_before_step", int'(port_data), 16'h0000);
        idle(1);
        @(negedge clk);
        chk("dy5_port", int'(port_data), 16'h0001);
        chk("dy5_acc_y", int'(dut.r_acc_y), 1);
        chk("dy5_mode", int'(mouse_mode), 1);

        // Negative X steps and held flag
        wr(16'h0000, 1);
        wr(16'h0008, 1);
        pkt(-3, 0, 0, 0);
        pkt(-2, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("dx_neg_port", int'(port_data), 16'h0008);
        chk("dx_neg_acc", int'(dut.r_acc_x), -1);
        pkt(-9, 0, 0, 0);
        idle(2);
        @(negedge clk);
        chk("dx_held_port", int'(port_data), 16'h0008);
        chk("dx_held_acc", int'(dut.r_acc_x), -10);

        // Positive X step
        pkt(4, 0, 0, 0);
        pkt(4, 0, 0, 0);
        idle(2);

        // Saturation
        wr(16'h0000, 1);
        wr(16'h0008, 1);
        for (int i = 0; i < 200; i++) pkt(0, 255, 0, 0);
        idle(1);
        @(negedge clk);
        chk("sat_acc_y", int'(dut.r_acc_y), 1023);
        chk("sat_port", int'(port_data), 16'h0001);
        for (int i = 0; i < 3; i++) pkt(0, -256, 0, 0);
        wr(16'h0000, 1);
        @(negedge clk);
        chk("clear_port", int'(port_data), 16'h0000);
        chk("clear_en", int'(mouse_en), 0);
        chk("clear_acc_y", int'(dut.r_acc_y), 0);

        // Joystick overrides mouse mode
        joy = 8'h05;
        for (int i = 0; i < 3; i++) pkt(1, 1, 1, 1);
        @(negedge clk);
        chk("joy_port", int'(port_data), 16'h0005);
        chk("joy_mode", int'(mouse_mode), 0);
        joy = 8'h00;
        pkt(0, 0, 1, 0);
        @(negedge clk);
        chk("joy_rel_mode", int'(mouse_mode), 1);
        chk("joy_rel_port", int'(port_data), 16'h0020);

        // Write coinciding with packet
        wr(16'h0008, 1);
        pkt(0, 5, 0, 0);
        idle(1);
        drive(1, 1, 16'h0000, 1, 0, 8, 0, 1);
        @(negedge clk);
        chk("wrpkt_port", int'(port_data), 16'h0040);
        chk("wrpkt_acc_y", int'(dut.r_acc_y), 0);
        wr(16'h0008, 0);
        @(negedge clk);
        chk("sel0_en_stays0", int'(mouse_en), 0);
        wr(16'h0008, 1);
        drive(1, 1, 16'h0008, 1, 0, 9, 0, 0);
        idle(1);
        @(negedge clk);
        chk("wr8pkt_acc_y", int'(dut.r_acc_y), 0);
        wr(16'h0000, 0);
        @(negedge clk);
        chk("sel0_en_stays1", int'(mouse_en), 1);

        // Joy and packet together -> joystick mode
        joy = 8'h80;
        pkt(0, 0, 1, 1);
        @(negedge clk);
        chk("joy_pkt_mode", int'(mouse_mode), 0);
        joy = 8'h00;

        // Reset beats simultaneous packet and write
        reset = 1;
        drive(1, 1, 16'h0008, 1, 0, 5, 1, 1);
        reset = 0;
        @(negedge clk);
        chk("rst_prio_port", int'(port_data), 16'h0000);
        chk("rst_prio_en", int'(mouse_en), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
